sn74hc165_reader: RTL
=====================

# sn74hc165_reader

Serial key-input reader for the traffic-light board: periodically loads an external SN74HC165 parallel-in/serial-out shift register, clocks its contents in MSB-first, and presents the inputs as a registered, optionally debounced key vector with one-cycle press/release pulses. It is the input-side counterpart of the SN74HC595 output driver. It sits between the board's shift-register pins and the top-level control FSM, which uses the pulses for mode, plus/minus and interrupt requests.

## Interface
- `CLK_DIV`, 6: clk cycles per half-period of `SN74HC165_clk`; minimum 1. Default gives 1 MHz at 12 MHz.
- `SCAN_PERIOD`, 12000: clk cycles between scan starts (1 ms at 12 MHz). Must exceed `2*CLK_DIV*(NBITS+1)+2`.
- `NBITS`, 8: number of inputs; 8 per cascaded device.
- `ACTIVE_LOW`, 1: 1 means a raw 0 is a pressed key, so raw bits are inverted before use.
- `DEBOUNCE_SCANS`, 10: consecutive agreeing scans required to change a stable bit. Used only with `SN74HC165_DEBOUNCE_EN`.

Ports:
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `SN74HC165_data` in 1: device Q7 serial output.
- `SN74HC165_load_n` out 1: device PL, active-low parallel load.
- `SN74HC165_clk` out 1: device shift clock.
- `o_keys` out NBITS: stable key levels, 1 = pressed.
- `o_press_pulse` out NBITS: one-clk pulse when an `o_keys` bit goes 0→1.
- `o_release_pulse` out NBITS: one-clk pulse when an `o_keys` bit goes 1→0.
- `o_valid` out 1: one-clk pulse when each scan completes.

## Operation
- **Scan timer.** Free-running counter from 0 to SCAN_PERIOD-1. It issues a tick on wrap.
- **Tick handling.** A tick in IDLE starts a scan. A tick while a scan is in progress is dropped.
- **FSM states:** IDLE → LOAD → SETTLE → SHIFT → DONE → IDLE.
- **LOAD:** `load_n`=0 for CLK_DIV cycles.
- **SETTLE:** `load_n`=1 for CLK_DIV cycles, `sck`=0.
- **SHIFT, per bit slot k = 0..NBITS-1** (2*CLK_DIV cycles each):
  - `sck`=0 for the first CLK_DIV cycles.
  - `SN74HC165_data` is sampled on the last low cycle into `raw[NBITS-1-k]`, so the first bit is device input H, mapped to bit NBITS-1.
  - `sck`=1 for the next CLK_DIV cycles, except the final slot, which keeps `sck`=0.
- **DONE:** one cycle.
  - Capture `cur = ACTIVE_LOW ? ~raw : raw`.
  - Pulse `o_valid`.
  - Hand `cur` to the debounce/update stage.
- **Update without debounce:** `o_keys <= cur`, asserted in the same cycle as `o_valid`.
- **Edge pulses:**
  - `o_press_pulse = cur & ~o_keys_prev`.
  - `o_release_pulse = ~cur & o_keys_prev`.
  - Both last exactly one clk.
- **Simultaneous edges:** any mix of bits may pulse in the same cycle.
- **Press and release:** the same bit can never assert both pulses at once.

## Timing
- **Reset values:** `SN74HC165_load_n`=1, `SN74HC165_clk`=0, `o_keys`=0, pulses=0, `o_valid`=0, FSM=IDLE, timer=0.
- **Reset mid-scan:** the scan is abandoned and outputs return to reset values immediately. The first scan starts at the first tick, SCAN_PERIOD cycles after release.
- **Tick to `o_valid`:** tick in cycle T → `load_n` low in T+1..T+CLK_DIV → `o_valid` in cycle T+1+2*CLK_DIV*(NBITS+1). With defaults this is T+109.
- **Pulse timing:**
  - Without debounce, pulses coincide with `o_valid`.
  - With debounce, they occur one cycle after `o_valid`.
- **Output registration:** all device pins are registered outputs, with no combinational path from input.
- **Shift clock:** `sck` duty is 50% during shift. Exactly NBITS-1 rising edges occur per scan.

## Configuration
- **`SN74HC165_DEBOUNCE_EN` defined:**
  - Each bit has a saturating counter of width clog2(DEBOUNCE_SCANS+1).
  - At each DONE, if `cur[i]` equals stable `o_keys[i]`, the counter clears. Otherwise it increments.
  - On reaching DEBOUNCE_SCANS, `o_keys[i]` flips, the matching pulse fires and the counter clears.
  - Counters reset to 0.
- **Undefined:** no counters are built. `o_keys` follows each scan directly, as in Operation.

## Structure
- **Shared package `sn74hc165_pkg`:** FSM state enumeration (IDLE, LOAD, SETTLE, SHIFT, DONE) and the default CLK_DIV/SCAN_PERIOD constants.
- **Sub-module `key_debounce`:** one per bit, generated NBITS times. It is compiled only under `SN74HC165_DEBOUNCE_EN` and takes `clk`, `rst_n`, a sample strobe and the bit value. It outputs the stable level and the press/release pulses.

## Test plan
- **Reset pins:** hold `rst_n`=0 → `load_n`=1, `sck`=0, `o_keys`=0.
- **First scan and bit order:** release reset with device model inputs H..A = 8'b0111_1110 (raw, active-low) and CLK_DIV=6, SCAN_PERIOD=12000, debounce off → the first `o_valid` comes 12000+109 cycles after release, with `o_keys`=8'h81 and `o_press_pulse`=8'h81 for one cycle.
- **Shift-clock shape:** per scan, exactly 7 `sck` rising edges, each high 6 cycles, and `load_n` low for exactly 6 cycles.
- **Debounce filter:** with `SN74HC165_DEBOUNCE_EN` and DEBOUNCE_SCANS=10, toggle input A low for 9 scans then high → no pulse. Hold it low for 10 scans → a single `o_press_pulse[0]` one cycle after the 10th `o_valid`.
- **Release pulse:** release all keys after they are stable → `o_release_pulse`=8'h81 for one cycle and `o_keys`=0.
- **Reset mid-scan:** assert `rst_n` mid-SHIFT → pins return to reset values in the same cycle, and no `o_valid` occurs until SCAN_PERIOD after release.

Source files
------------

// File: rtl/sn74hc165_pkg.sv
// ============================================================================
// sn74hc165_pkg : shared scan-FSM state encoding and default timing constants
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

package sn74hc165_pkg;

  localparam int unsigned C_DEF_CLK_DIV     = 6;
  localparam int unsigned C_DEF_SCAN_PERIOD = 12000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sn74hc165_reader_if.sv
// ============================================================================
// sn74hc165_reader_if : device pins plus key-vector outputs of the reader
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sn74hc165_reader_if #(
  parameter int unsigned NBITS = 8
);
  logic             SN74HC165_data;
  logic             SN74HC165_load_n;
  logic             SN74HC165_clk;
  logic [NBITS-1:0] o_keys;
  logic [NBITS-1:0] o_press_pulse;
  logic [NBITS-1:0] o_release_pulse;
  logic             o_valid;

  modport master (
    input  SN74HC165_data,
    output SN74HC165_load_n, SN74HC165_clk,
    output o_keys, o_press_pulse, o_release_pulse, o_valid
  );

  modport slave (
    output SN74HC165_data,
    input  SN74HC165_load_n, SN74HC165_clk,
    input  o_keys, o_press_pulse, o_release_pulse, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/sn74hc165_reader_key_debounce.sv
// ============================================================================
// key_debounce : per-key scan-count filter with press/release pulses
//                (built only when SN74HC165_DEBOUNCE_EN is defined)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef SN74HC165_DEBOUNCE_EN
module key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 10
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic sample_i,
  input  wire logic bit_i,
  output logic      stable_o,
  output logic      press_o,
  output logic      release_o
);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_FLIP = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample_i) begin
      if (bit_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_FLIP) begin
        // This scan is the DEBOUNCE_SCANS-th consecutive disagreement
        cnt_d     = '0;
        stable_d  = bit_i;
        press_d   = bit_i;
        release_d = ~bit_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign stable_o  = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule
`endif

`default_nettype wire

// File: rtl/sn74hc165_reader.sv
// ============================================================================
// sn74hc165_reader : periodic SN74HC165 scanner producing key levels/pulses
//                    optional filter: define SN74HC165_DEBOUNCE_EN
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module sn74hc165_reader
  import sn74hc165_pkg::*;
#(
  parameter int unsigned CLK_DIV        = C_DEF_CLK_DIV,
  parameter int unsigned SCAN_PERIOD    = C_DEF_SCAN_PERIOD,
  parameter int unsigned NBITS          = 8,
  parameter int unsigned ACTIVE_LOW     = 1,
  parameter int unsigned DEBOUNCE_SCANS = 10
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sn74hc165_reader_if.master bus
);
  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned TMR_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(NBITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(SCAN_PERIOD - 1);

  if (CLK_DIV < 1 || NBITS < 1 || DEBOUNCE_SCANS < 1 ||
      SCAN_PERIOD <= 2 * CLK_DIV * (NBITS + 1) + 2) begin : g_param_check
    $error("sn74hc165_reader: illegal parameter combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [TMR_W-1:0] timer_q;
  logic             tick_q;
  logic             load_n_q, load_n_d;
  logic             sck_q, sck_d;
  logic             valid_q, valid_d;
  logic [NBITS-1:0] raw_q;
  logic [BIT_W-1:0] raw_idx;
  logic             sample_now;
  logic [NBITS-1:0] cur;
  logic [NBITS-1:0] keys, press, release_p;

  // Tick is registered so the first scan begins SCAN_PERIOD cycles after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      timer_q <= (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;
      tick_q  <= (timer_q == TMR_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_DIV_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_SLOT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state so the pins are flops aligned with state_q
  always_comb begin
    load_n_d = (state_d != ST_LOAD);
    sck_d    = (state_d == ST_SHIFT) && (cnt_d > CNT_DIV_LAST) && (bit_d != BIT_LAST);
    valid_d  = (state_d == ST_DONE);
  end

  assign sample_now = (state_q == ST_SHIFT) && (cnt_q == CNT_DIV_LAST);
  assign raw_idx    = BIT_LAST - bit_q;
  assign cur        = (ACTIVE_LOW != 0) ? ~raw_q : raw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_n_q <= 1'b1;
      sck_q    <= 1'b0;
      valid_q  <= 1'b0;
      raw_q    <= '0;
    end else begin
      load_n_q <= load_n_d;
      sck_q    <= sck_d;
      valid_q  <= valid_d;
      if (sample_now) begin
        raw_q[raw_idx] <= bus.SN74HC165_data;
      end
    end
  end

`ifdef SN74HC165_DEBOUNCE_EN
  logic [NBITS-1:0] cur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
    end else if (valid_d) begin
      cur_q <= cur;
    end
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_debounce
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_key_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_i (valid_q),
      .bit_i    (cur_q[i]),
      .stable_o (keys[i]),
      .press_o  (press[i]),
      .release_o(release_p[i])
    );
  end
`else
  logic [NBITS-1:0] keys_q, press_q, release_q;

  // Keys update on the edge into DONE, so they coincide with o_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= valid_d ? (cur & ~keys_q) : '0;
      release_q <= valid_d ? (~cur & keys_q) : '0;
      if (valid_d) begin
        keys_q <= cur;
      end
    end
  end

  assign keys      = keys_q;
  assign press     = press_q;
  assign release_p = release_q;
`endif

  assign bus.SN74HC165_load_n = load_n_q;
  assign bus.SN74HC165_clk    = sck_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_keys           = keys;
  assign bus.o_press_pulse    = press;
  assign bus.o_release_pulse  = release_p;

endmodule

`default_nettype wire
